wb_port_arbiter: RTL

Shares the single register-file write port between the in-order pipeline write-back path (`pipe_*`) and a long-latency unit (`lu_*`), for example a multi-cycle mul/div or a load-miss return. Long-latency results wait in a small FIFO and drain in cycles where the pipeline is not writing. A wait counter forces a one-cycle pipeline stall so the FIFO cannot starve. The block sits between the write-back stage outputs and the register file write port.

---
 rtl/wb_port_arbiter_if.sv | 51 +++++
 rtl/wb_port_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - write-back port arbiter bus bundle
//
// Signals:
//   pipe_we/pipe_rd/pipe_data  pipeline write-back request
//   pipe_stall                 forced one-cycle pipeline hold
//   lu_valid/lu_ready/lu_rd/lu_data  long-latency result handshake
//   rf_we/rf_rd/rf_wdata       registered register-file write port
//   pend_count                 buffered long-latency result count
//   rs1_addr/rs2_addr/pend_hazard  only with WB_ARB_HAZARD_EN
// Modports: slave (arbiter side), master (driver side).
interface wb_port_arbiter_if #(
  parameter int FIFO_DEPTH = 2
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          pipe_we;
  logic [4:0]    pipe_rd;
  logic [31:0]   pipe_data;
  logic          pipe_stall;
  logic          lu_valid;
  logic          lu_ready;
  logic [4:0]    lu_rd;
  logic [31:0]   lu_data;
  logic          rf_we;
  logic [4:0]    rf_rd;
  logic [31:0]   rf_wdata;
  logic [CW-1:0] pend_count;
`ifdef WB_ARB_HAZARD_EN
  logic [4:0]    rs1_addr;
  logic [4:0]    rs2_addr;
  logic          pend_hazard;
`endif

  modport slave (
    input  pipe_we, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
`ifdef WB_ARB_HAZARD_EN
    input  rs1_addr, rs2_addr,
    output pend_hazard,
`endif
    output pipe_stall, lu_ready, rf_we, rf_rd, rf_wdata, pend_count
  );

  modport master (
    output pipe_we, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
`ifdef WB_ARB_HAZARD_EN
    output rs1_addr, rs2_addr,
    input  pend_hazard,
`endif
    input  pipe_stall, lu_ready, rf_we, rf_rd, rf_wdata, pend_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter, pipeline vs long-latency FIFO
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   wb_port_arbiter_if.slave (pipe_*, lu_*, rf_*, pipe_stall, pend_count)
// Optional macro WB_ARB_HAZARD_EN adds rs1_addr/rs2_addr inputs and the
// pend_hazard output (match of a nonzero source against any buffered rd).
module wb_port_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic                clk,
  input  logic                rst,
  wb_port_arbiter_if.slave    bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  // Result buffer; x0 results are never stored.
  logic [4:0]    q_rd   [FIFO_DEPTH];
  logic [31:0]   q_data [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_cnt;

  logic          rf_we_q;
  logic [4:0]    rf_rd_q;
  logic [31:0]   rf_wdata_q;

  logic          stall;
  logic          pipe_write;
  logic          pop;
  logic          push;
  logic          store;
  logic          not_full;

  // Stall depends only on registered state so no input can reach it.
  always_comb begin
    not_full   = (count < CW'(FIFO_DEPTH));
    stall      = (count != '0) && (wait_cnt == WW'(MAX_WAIT));
    pipe_write = bus.pipe_we && (bus.pipe_rd != 5'd0) && !stall;
    pop        = (count != '0) && !pipe_write;
    // Room is judged on the registered count; a same-cycle pop frees nothing.
    push       = bus.lu_valid && !rst && not_full;
    store      = push && (bus.lu_rd != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      if (store) wr_ptr <= wr_ptr + PW'(1);

      case ({store, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // Counts cycles the head has been denied; reaching MAX_WAIT forces
      // exactly one stall, whose pop clears it again.
      if (pop || (count == '0))
        wait_cnt <= '0;
      else if (wait_cnt != WW'(MAX_WAIT))
        wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // Payload storage needs no reset: validity is carried by count/pointers.
  always_ff @(posedge clk) begin
    if (store) begin
      q_rd[wr_ptr]   <= bus.lu_rd;
      q_data[wr_ptr] <= bus.lu_data;
    end
  end

  // Registered write port; address/data hold when no write happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else if (pipe_write) begin
      rf_we_q    <= 1'b1;
      rf_rd_q    <= bus.pipe_rd;
      rf_wdata_q <= bus.pipe_data;
    end else if (pop) begin
      rf_we_q    <= 1'b1;
      rf_rd_q    <= q_rd[rd_ptr];
      rf_wdata_q <= q_data[rd_ptr];
    end else begin
      rf_we_q    <= 1'b0;
    end
  end

  assign bus.lu_ready   = !rst && not_full;
  assign bus.pipe_stall = stall;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.pend_count = count;

`ifdef WB_ARB_HAZARD_EN
  logic          hazard;
  logic [PW-1:0] idx;

  // Walk the live entries from the head; slot i is valid while i < count.
  always_comb begin
    hazard = 1'b0;
    idx    = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if ((bus.rs1_addr != 5'd0) && (q_rd[idx] == bus.rs1_addr)) hazard = 1'b1;
        if ((bus.rs2_addr != 5'd0) && (q_rd[idx] == bus.rs2_addr)) hazard = 1'b1;
      end
    end
  end

  assign bus.pend_hazard = hazard && !rst;
`endif

endmodule
